// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register link (transmitter and receiver).
package sr_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } sr_state_e;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial link signals of the PISO transmitter.
interface piso_serializer_if #(
  parameter int unsigned N = 4
);
  logic         load_valid;
  logic [N-1:0] load_data;
  logic         load_ready;
  logic         halt;
  logic         ser_out;
  logic         ser_en;
  logic         done;
  logic         busy;

  // Source side: offers words and controls halt.
  modport master (
    output load_valid, load_data, halt,
    input  load_ready, ser_out, ser_en, done, busy
  );

  // Serializer side.
  modport slave (
    input  load_valid, load_data, halt,
    output load_ready, ser_out, ser_en, done, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: sends an N-bit word LSB first with a shift enable.
module piso_serializer
  import sr_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

  localparam int unsigned CntW = clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  sr_state_e       state_q;
  logic [N-1:0]    sreg_q;
  logic [CntW-1:0] cnt_q;

  logic shifting;
  logic done;
  logic ready;
  logic accept;

  // Handshake and completion decode; done lets a new word load in the last-bit cycle.
  always_comb begin
    shifting = (state_q == StShift);
    done     = shifting && (cnt_q == CntLast) && !bus.halt;
    ready    = !shifting || done;
    accept   = bus.load_valid && ready;
  end

  // FSM, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= StShift;
      sreg_q  <= bus.load_data;
      cnt_q   <= '0;
    end else if (shifting && !bus.halt) begin
      sreg_q <= sreg_q >> 1;
      if (done) begin
        state_q <= StIdle;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Serial outputs; ser_out keeps showing the pending bit while halted.
  always_comb begin
    bus.ser_out    = shifting & sreg_q[0];
    bus.ser_en     = shifting & !bus.halt;
    bus.busy       = shifting;
    bus.done       = done;
    bus.load_ready = ready;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: piso_serializer (N=4 and N=8) driving a right-shifting receiver model.
module tb_piso_serializer;

  logic clk;
  logic rst_n;

  piso_serializer_if #(.N(4)) bus4 ();
  piso_serializer_if #(.N(8)) bus8 ();

  piso_serializer #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  piso_serializer #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: shifts right, new bit into MSB.
  logic [3:0] rx4;
  logic [7:0] rx8;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx4 <= '0;
      rx8 <= '0;
    end else begin
      if (bus4.ser_en) rx4 <= {bus4.ser_out, rx4[3:1]};
      if (bus8.ser_en) rx8 <= {bus8.ser_out, rx8[7:1]};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after inputs are set at a falling edge.
  task automatic expect4(input string tag, input logic o, input logic en, input logic d,
                         input logic rdy, input logic bsy);
    #1;
    check({tag, " ser_out"},    32'(bus4.ser_out),    32'(o));
    check({tag, " ser_en"},     32'(bus4.ser_en),     32'(en));
    check({tag, " done"},       32'(bus4.done),       32'(d));
    check({tag, " load_ready"}, 32'(bus4.load_ready), 32'(rdy));
    check({tag, " busy"},       32'(bus4.busy),       32'(bsy));
  endtask

  // Unhalted bit cycles first..last of a 4-bit word; returns on the next falling edge.
  task automatic bits4(input string tag, input logic [3:0] word, input int first,
                       input int last);
    for (int k = first; k <= last; k++) begin
      expect4($sformatf("%s bit%0d", tag, k), word[k], 1'b1, k == 3, k == 3, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus4.load_valid = 1'b0;
    bus4.load_data  = '0;
    bus4.halt       = 1'b0;
    bus8.load_valid = 1'b0;
    bus8.load_data  = '0;
    bus8.halt       = 1'b0;

    #3;
    expect4("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word 1011.
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b1011;
    expect4("t1 offer", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bits4("t1", 4'b1011, 0, 3);
    expect4("t1 after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1 rx", 32'(rx4), 32'h0000000b);

    // Back-to-back 0110 then 1001 with valid held.
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b0110;
    @(negedge clk);
    bus4.load_data  = 4'b1001;
    bits4("b2b w0", 4'b0110, 0, 3);
    check("b2b rx w0", 32'(rx4), 32'h00000006);
    bus4.load_valid = 1'b0;
    bits4("b2b w1", 4'b1001, 0, 3);
    expect4("b2b after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b rx w1", 32'(rx4), 32'h00000009);

    // Halt for 3 cycles after bit 1 of 1100.
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b1100;
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bits4("hmid", 4'b1100, 0, 1);
    bus4.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect4($sformatf("hmid halt%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    bus4.halt = 1'b0;
    bits4("hmid", 4'b1100, 2, 3);
    expect4("hmid after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hmid rx", 32'(rx4), 32'h0000000c);

    // Halt on the last bit of 0101 with the next word 0011 already offered.
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b0101;
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bits4("hlast", 4'b0101, 0, 2);
    bus4.halt       = 1'b1;
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      expect4($sformatf("hlast halt%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    bus4.halt = 1'b0;
    expect4("hlast bit3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("hlast rx w0", 32'(rx4), 32'h00000005);
    bus4.load_valid = 1'b0;
    bits4("hlast next", 4'b0011, 0, 3);
    expect4("hlast after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hlast rx w1", 32'(rx4), 32'h00000003);

    // Asynchronous reset between edges in the middle of 1111.
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b1111;
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bits4("arst", 4'b1111, 0, 1);
    #2;
    rst_n = 1'b0;
    expect4("arst asserted", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.load_valid = 1'b1;
    bus4.load_data  = 4'b0001;
    expect4("arst released", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bits4("arst next", 4'b0001, 0, 3);
    check("arst rx", 32'(rx4), 32'h00000001);

    // N=8 instance: A5.
    bus8.load_valid = 1'b1;
    bus8.load_data  = 8'hA5;
    @(negedge clk);
    bus8.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("n8 bit%0d ser_out", k), 32'(bus8.ser_out), 32'((8'hA5 >> k) & 8'h01));
      check($sformatf("n8 bit%0d ser_en", k),  32'(bus8.ser_en),  32'd1);
      check($sformatf("n8 bit%0d done", k),    32'(bus8.done),    32'(k == 7));
      @(negedge clk);
    end
    #1;
    check("n8 busy after", 32'(bus8.busy), 32'd0);
    check("n8 rx", 32'(rx8), 32'h000000a5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: the sending end of the team's serial-in shift register link.
- Accepts an N-bit word via valid/ready handshake and emits it LSB first, one bit per clock, with a qualifying enable.
- Intended wiring: `ser_out` drives the receiver's `in`, `ser_en` drives its `en`. After N enabled cycles the receiver (which shifts right, new bit into MSB) holds the original word unchanged.

Parameters:
- N, 4, word width in bits; legal range 2..32.

Ports:
- clk  input  1  single rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  word on load_data is offered
- load_data  input  N  parallel word to transmit
- load_ready  output  1  block can accept a word this cycle
- halt  input  1  freeze transmission in place while high
- ser_out  output  1  serial data bit, LSB first
- ser_en  output  1  ser_out is a valid bit this cycle (receiver shift enable)
- done  output  1  one-cycle pulse coincident with the last bit of a word
- busy  output  1  word in flight (state SHIFT)

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=0, ser_en=0, done=0, busy=0.
  - load_ready=1 once state is IDLE; it reads 1 during reset.
- States:
  - IDLE: no word held.
  - SHIFT: word held; counter cnt ranges 0..N-1, width CNT_W=clog2(N).
- Accept:
  - Handshake fires when load_valid && load_ready at a rising edge.
  - On that edge: sreg<=load_data, cnt<=0, state<=SHIFT.
- Combinational outputs:
  - In SHIFT: ser_out=sreg[0], ser_en = !halt, busy=1.
  - In IDLE: ser_out=0, ser_en=0, busy=0.
- Latency: the first bit appears the cycle after the accepting edge. Bit k (k=0..N-1) appears in the k-th unhalted SHIFT cycle.
- SHIFT, halt=0, at each edge:
  - sreg<=sreg>>1 (zero fill).
  - If cnt==N-1: the word is complete. Otherwise cnt<=cnt+1.
- SHIFT, halt=1: sreg and cnt hold; ser_en=0; done=0; ser_out keeps showing the pending bit.
- done = SHIFT && cnt==N-1 && !halt. It is combinational and asserts in the same cycle as the final ser_en.
- load_ready = IDLE || done. This gives back-to-back words with no gap.
- End of word (done cycle) at the edge:
  - If load_valid: new word is loaded, cnt<=0, state stays SHIFT.
  - Otherwise: state<=IDLE.
- halt in IDLE: no effect; a word may still be accepted.
- load_valid while busy and not done: ignored. The offered word must be held by the source until accepted.
- Reset asserted mid-word: the word is abandoned immediately and all outputs go to reset values. No partial completion or done pulse.
- load_data must be stable only in the accepting cycle.
- Throughput: one word per N clocks with halt=0.

Decomposition:
- Shared package sr_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1
  - clog2 constant function used for CNT_W, also reused by the receiver bench
- No sub-module; counter and shifter stay inline (about 150 lines).
- The test bench instantiates piso_serializer feeding the existing shift register receiver, with the same N.

Test Plan:
- Reset then single word, N=4: load 4'b1011 -> ser_out 1,1,0,1 on 4 cycles, ser_en=1 each, done on 4th. Receiver r=4'b1011 after 4th edge; busy drops next cycle.
- Back-to-back: offer 4'b0110 then 4'b1001 with load_valid held -> 8 contiguous ser_en cycles, bits 0,1,1,0,1,0,0,1. load_ready high only in IDLE and the two done cycles; receiver shows 0110 then 1001.
- halt mid-word: load 4'b1100, raise halt for 3 cycles after bit 1 -> ser_en=0 and ser_out=1 (pending bit2) during halt. Done is delayed 3 cycles; receiver still ends 4'b1100.
- halt on last bit: halt high while cnt==3 -> done=0, load_ready=0 until halt drops. Then done fires and the next word is accepted.
- Async reset mid-word: load 4'b1111, pull rst_n low between edges after bit 1 -> ser_out, ser_en, busy drop at once with no clock. After release, load_ready=1 and the next word 4'b0001 transmits correctly.
- N=8 build: load 8'hA5 -> bits 1,0,1,0,0,1,0,1 on 8 cycles; done on 8th; 8-bit receiver holds 8'hA5.
